// File: rtl/ex_div_unit_pkg.sv
// Shared encodings for the EX-stage divider: FSM states and the stall/reset/result
// handshake constants used across the pipeline.
package ex_div_unit_pkg;

  typedef enum logic [1:0] {
    DIV_IDLE  = 2'b00,
    DIV_BUSY  = 2'b01,
    DIV_DZERO = 2'b10,
    DIV_DONE  = 2'b11
  } div_state_e;

  localparam logic STOP    = 1'b1;
  localparam logic NO_STOP = 1'b0;

  localparam logic RST_ENABLE = 1'b0;

  localparam logic DIV_RESULT_READY     = 1'b1;
  localparam logic DIV_RESULT_NOT_READY = 1'b0;

endpackage

// File: rtl/ex_div_unit.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU. It holds the pipeline via stop_req
// while iterating, and returns remainder on hi and quotient on lo.
module ex_div_unit
  import ex_div_unit_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             signed_div,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             stall_ex,
  input  logic             flush,
  output logic             stop_req,
  output logic             result_valid,
  output logic [WIDTH-1:0] result_hi,
  output logic [WIDTH-1:0] result_lo
);

  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  div_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvsr_q, dvsr_d;
  logic             neg_quo_q, neg_quo_d;
  logic             neg_rem_q, neg_rem_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             valid_q, valid_d;

  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_abs, b_abs;
  logic [WIDTH-1:0] step_rem, step_quo;

  // One restoring step: the quotient register doubles as the dividend shifter, so its
  // MSB feeds the remainder and the new quotient bit enters at the LSB.
  function automatic logic [2*WIDTH-1:0] div_step(
    input logic [WIDTH-1:0] rem,
    input logic [WIDTH-1:0] quo,
    input logic [WIDTH-1:0] dvsr
  );
    logic [WIDTH:0] trial;
    trial = {rem, quo[WIDTH-1]};
    if (trial >= {1'b0, dvsr}) begin
      return {trial[WIDTH-1:0] - dvsr, quo[WIDTH-2:0], 1'b1};
    end
    return {trial[WIDTH-1:0], quo[WIDTH-2:0], 1'b0};
  endfunction

  assign a_neg = signed_div & dividend[WIDTH-1];
  assign b_neg = signed_div & divisor[WIDTH-1];
  assign a_abs = a_neg ? -dividend : dividend;
  assign b_abs = b_neg ? -divisor : divisor;

  assign {step_rem, step_quo} = div_step(rem_q, quo_q, dvsr_q);

  // Reset is folded in so the request drops immediately rather than at the next edge.
  assign stop_req = ((rst != RST_ENABLE) && start && !flush && (state_q != DIV_DONE))
                    ? STOP : NO_STOP;

  assign result_valid = valid_q;
  assign result_hi    = hi_q;
  assign result_lo    = lo_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvsr_d    = dvsr_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    valid_d   = valid_q;

    if (flush) begin
      state_d = DIV_IDLE;
      valid_d = DIV_RESULT_NOT_READY;
    end else begin
      case (state_q)
        DIV_IDLE: begin
          if (start) begin
            if (divisor == '0) begin
              state_d = DIV_DZERO;
            end else begin
              quo_d     = a_abs;
              dvsr_d    = b_abs;
              neg_quo_d = a_neg ^ b_neg;
              neg_rem_d = a_neg;
              rem_d     = '0;
              cnt_d     = '0;
              state_d   = DIV_BUSY;
            end
          end
        end
        DIV_BUSY: begin
          if (!start) begin
            state_d = DIV_IDLE;
          end else begin
            rem_d = step_rem;
            quo_d = step_quo;
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == LAST_ITER) begin
              hi_d    = neg_rem_q ? -step_rem : step_rem;
              lo_d    = neg_quo_q ? -step_quo : step_quo;
              valid_d = DIV_RESULT_READY;
              state_d = DIV_DONE;
            end
          end
        end
        DIV_DZERO: begin
          if (!start) begin
            state_d = DIV_IDLE;
          end else begin
            hi_d    = '0;
            lo_d    = '0;
            valid_d = DIV_RESULT_READY;
            state_d = DIV_DONE;
          end
        end
        DIV_DONE: begin
          // The result is consumed in the first cycle the EX stage is allowed to advance.
          if (!stall_ex) begin
            state_d = DIV_IDLE;
            valid_d = DIV_RESULT_NOT_READY;
          end
        end
        default: state_d = DIV_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (rst == RST_ENABLE) begin
      state_q   <= DIV_IDLE;
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvsr_q    <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      valid_q   <= DIV_RESULT_NOT_READY;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dvsr_q    <= dvsr_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      valid_q   <= valid_d;
    end
  end

endmodule

// File: tb/tb_ex_div_unit.sv
// Randomized bench for ex_div_unit: every divide is checked against 64-bit reference
// arithmetic, along with stall length, hold-in-DONE, flush, abort and reset behaviour.
module tb_ex_div_unit;

  logic        clk;
  logic        rst;
  logic        start;
  logic        signed_div;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        stall_ex;
  logic        flush;
  logic        stop_req;
  logic        result_valid;
  logic [31:0] result_hi;
  logic [31:0] result_lo;

  int n_checks = 0;
  int n_fail   = 0;

  ex_div_unit #(.WIDTH(32), .CNT_W(6)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .signed_div  (signed_div),
    .dividend    (dividend),
    .divisor     (divisor),
    .stall_ex    (stall_ex),
    .flush       (flush),
    .stop_req    (stop_req),
    .result_valid(result_valid),
    .result_hi   (result_hi),
    .result_lo   (result_lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: truncating division in 64-bit arithmetic, result wrapped to 32 bits.
  function automatic void ref_div(input bit sgn, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] q, output logic [31:0] r);
    longint sa, sb, sq, sr;
    if (b == 32'd0) begin
      q = 32'd0;
      r = 32'd0;
      return;
    end
    if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'({32'd0, a});
      sb = longint'({32'd0, b});
    end
    sq = sa / sb;
    sr = sa % sb;
    q  = sq[31:0];
    r  = sr[31:0];
  endfunction

  // Issue one divide with stall_ex mirroring stop_req, then hold DONE for 'hold' cycles.
  task automatic run_div(input bit sgn, input logic [31:0] a, input logic [31:0] b, input int hold);
    logic [31:0] exp_q, exp_r;
    int cyc, n_stop, exp_lat;
    bit got;
    ref_div(sgn, a, b, exp_q, exp_r);
    exp_lat = (b == 32'd0) ? 2 : 33;
    @(negedge clk);
    start = 1'b1; signed_div = sgn; dividend = a; divisor = b; flush = 1'b0;
    cyc = 0; n_stop = 0; got = 1'b0;
    while (!got && cyc < 60) begin
      #1;
      stall_ex = stop_req;
      if (stop_req) n_stop++;
      if (result_valid) begin
        got = 1'b1;
      end else begin
        @(negedge clk);
        cyc++;
        dividend = $urandom;
        divisor  = $urandom;
      end
    end
    check("done_timeout", 64'(got), 64'd1);
    check("latency", 64'(cyc), 64'(exp_lat));
    check("stop_cycles", 64'(n_stop), 64'(exp_lat));
    check("hi", 64'(result_hi), 64'(exp_r));
    check("lo", 64'(result_lo), 64'(exp_q));
    check("stop_in_done", 64'(stop_req), 64'd0);
    for (int h = 0; h < hold; h++) begin
      stall_ex = 1'b1;
      @(negedge clk);
      #1;
      check("hold_valid", 64'(result_valid), 64'd1);
      check("hold_hi", 64'(result_hi), 64'(exp_r));
      check("hold_lo", 64'(result_lo), 64'(exp_q));
      check("hold_stop", 64'(stop_req), 64'd0);
    end
    stall_ex = 1'b0;
    start    = 1'b0;
    @(negedge clk);
    #1;
    check("released_valid", 64'(result_valid), 64'd0);
    $display("div sgn=%0d a=%08h b=%08h hold=%0d -> hi=%08h lo=%08h (exp hi=%08h lo=%08h) lat=%0d",
             sgn, a, b, hold, result_hi, result_lo, exp_r, exp_q, cyc);
  endtask

  initial begin
    logic [31:0] ra, rb;
    bit          rs;
    rst = 1'b0; start = 1'b0; signed_div = 1'b0; dividend = '0; divisor = '0;
    stall_ex = 1'b0; flush = 1'b0;
    #1;
    check("rst_valid", 64'(result_valid), 64'd0);
    check("rst_hi", 64'(result_hi), 64'd0);
    check("rst_lo", 64'(result_lo), 64'd0);
    check("rst_stop", 64'(stop_req), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    run_div(1'b0, 32'd100, 32'd7, 0);
    run_div(1'b1, 32'hFFFF_FFF9, 32'd2, 0);
    run_div(1'b1, 32'd7, 32'hFFFF_FFFE, 1);
    run_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_div(1'b0, 32'd5, 32'd0, 0);
    run_div(1'b0, 32'd1234, 32'd56, 3);

    // Flush at BUSY cycle 10
    @(negedge clk);
    start = 1'b1; signed_div = 1'b0; dividend = 32'd100; divisor = 32'd7;
    repeat (10) @(negedge clk);
    #1;
    check("busy_stop", 64'(stop_req), 64'd1);
    flush = 1'b1;
    #1;
    check("flush_stop", 64'(stop_req), 64'd0);
    @(negedge clk);
    flush = 1'b0; start = 1'b0;
    #1;
    check("flush_valid", 64'(result_valid), 64'd0);
    $display("flush in BUSY cycle 10 -> valid=%0d stop_req=%0d", result_valid, stop_req);
    run_div(1'b0, 32'd9, 32'd3, 0);

    // start withdrawn mid-BUSY aborts without a result
    @(negedge clk);
    start = 1'b1; dividend = 32'd77; divisor = 32'd5;
    repeat (5) @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("abort_valid", 64'(result_valid), 64'd0);
    $display("abort in BUSY -> valid=%0d", result_valid);
    run_div(1'b0, 32'd77, 32'd5, 0);

    // Reset at BUSY cycle 20
    @(negedge clk);
    start = 1'b1; signed_div = 1'b1; dividend = 32'hDEAD_BEEF; divisor = 32'd13;
    repeat (20) @(negedge clk);
    rst = 1'b0;
    #1;
    check("midrst_stop", 64'(stop_req), 64'd0);
    check("midrst_valid", 64'(result_valid), 64'd0);
    check("midrst_hi", 64'(result_hi), 64'd0);
    check("midrst_lo", 64'(result_lo), 64'd0);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      check("postrst_stop", 64'(stop_req), 64'd0);
      check("postrst_valid", 64'(result_valid), 64'd0);
    end
    $display("reset in BUSY cycle 20 -> outputs cleared");
    run_div(1'b1, 32'hDEAD_BEEF, 32'd13, 0);

    for (int n = 0; n < 16; n++) begin
      rs = 1'($urandom_range(0, 1));
      ra = $urandom;
      case ($urandom_range(0, 7))
        0:       rb = 32'd0;
        1:       rb = 32'($urandom_range(1, 15));
        2:       rb = 32'hFFFF_FFFF;
        3: begin ra = 32'h8000_0000; rb = $urandom; end
        default: rb = $urandom;
      endcase
      run_div(rs, ra, rb, $urandom_range(0, 2));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
